pc_update_unit: RTL and testbench

- Consumer of the 2-bit PC-source select produced by opcode decode. Holds the architectural PC and computes the next PC from that select: pc+4, pc+imm, or ALU result. Sequences instruction fetch and commit through valid/ready handshakes.
- Sits between IFU and EXU in the NPC core.
- Keeps a retired-instruction counter.
- Traps into a sticky halt state on an illegal select or a misaligned target.

---
 rtl/pc_update_unit.sv | 119 +++++++++++
 tb/tb_pc_update_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
// ============================================================================
//  Module   : pc_update_unit
//  Brief    : Architectural PC holder; sequences fetch/commit handshakes and
//             selects the next PC (pc+4, pc+imm, jalr target), trapping to halt.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_update_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
  parameter int              CNT_W     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       pc_src,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             commit_valid,
  output logic             commit_ready,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [XLEN-1:0]  fetch_pc,
  output logic [XLEN-1:0]  pc,
  output logic             halted,
  output logic [XLEN-1:0]  bad_target,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] c_src_seq  = 2'b00;
  localparam logic [1:0] c_src_br   = 2'b01;
  localparam logic [1:0] c_src_jalr = 2'b10;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_fetch_valid;
  logic             r_commit_ready;
  logic             r_halted;
  logic [XLEN-1:0]  r_bad_target;
  logic [CNT_W-1:0] r_instret;

  logic [XLEN-1:0]  w_target;
  logic             w_target_ok;

  // Illegal select reports the raw ALU value as the offending target.
  always_comb begin
    w_target = alu_result;
    case (pc_src)
      c_src_seq:  w_target = r_pc + XLEN'(4);
      c_src_br:   w_target = r_pc + imm;
      c_src_jalr: w_target = {alu_result[XLEN-1:1], 1'b0};
      default:    w_target = alu_result;
    endcase
    w_target_ok = (pc_src != 2'b11) && (w_target[1:0] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_BOOT;
      r_pc           <= RESET_VEC;
      r_fetch_valid  <= 1'b0;
      r_commit_ready <= 1'b0;
      r_halted       <= 1'b0;
      r_bad_target   <= '0;
      r_instret      <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state       <= S_FETCH;
          r_fetch_valid <= 1'b1;
        end
        S_FETCH: begin
          if (fetch_ready) begin
            r_state        <= S_EXEC;
            r_fetch_valid  <= 1'b0;
            r_commit_ready <= 1'b1;
          end
        end
        S_EXEC: begin
          if (commit_valid) begin
            r_commit_ready <= 1'b0;
            if (w_target_ok) begin
              r_state       <= S_FETCH;
              r_pc          <= w_target;
              r_instret     <= r_instret + CNT_W'(1);
              r_fetch_valid <= 1'b1;
            end else begin
              r_state      <= S_HALT;
              r_halted     <= 1'b1;
              r_bad_target <= w_target;
            end
          end
        end
        default: begin
          r_fetch_valid  <= 1'b0;
          r_commit_ready <= 1'b0;
        end
      endcase
    end
  end

  assign commit_ready = r_commit_ready;
  assign fetch_valid  = r_fetch_valid;
  assign fetch_pc     = r_pc;
  assign pc           = r_pc;
  assign halted       = r_halted;
  assign bad_target   = r_bad_target;
  assign instret      = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_pc_update_unit.sv
// ============================================================================
//  Module   : tb_pc_update_unit
//  Brief    : Randomized self-checking bench for pc_update_unit against a
//             transaction-level PC/instret model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_update_unit;

  localparam logic [31:0] c_reset_vec = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        commit_valid;
  logic        commit_ready;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] pc;
  logic        halted;
  logic [31:0] bad_target;
  logic [63:0] instret;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [63:0] m_instret;
  logic        m_halted;
  logic [31:0] m_bad;

  always #5 clk = ~clk;

  pc_update_unit #(
    .XLEN(32), .RESET_VEC(32'h8000_0000), .CNT_W(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .imm(imm),
    .alu_result(alu_result), .commit_valid(commit_valid),
    .commit_ready(commit_ready), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetch_pc(fetch_pc), .pc(pc),
    .halted(halted), .bad_target(bad_target), .instret(instret)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_arch(input string tag);
    check({tag, ".pc"}, 64'(pc), 64'(m_pc));
    check({tag, ".instret"}, instret, m_instret);
    check({tag, ".halted"}, 64'(halted), 64'(m_halted));
    check({tag, ".bad"}, 64'(bad_target), 64'(m_bad));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_pc = c_reset_vec; m_instret = '0; m_halted = 1'b0; m_bad = '0;
    check_arch("reset");
    check("reset.fetch_valid", 64'(fetch_valid), 64'd0);
    check("reset.commit_ready", 64'(commit_ready), 64'd0);
  endtask

  // Waits for the fetch request, stalls it, then completes the handshake.
  task automatic do_fetch(input int stall);
    int n = 0;
    while (!fetch_valid && n < 8) begin
      tick();
      n++;
    end
    check("fetch.wait", 64'(fetch_valid), 64'd1);
    check("fetch.pc", 64'(fetch_pc), 64'(m_pc));
    for (int i = 0; i < stall; i++) begin
      commit_valid = 1'($urandom_range(0, 1));
      pc_src = 2'($urandom);
      alu_result = $urandom;
      imm = $urandom;
      tick();
      check("stall.fetch_valid", 64'(fetch_valid), 64'd1);
      check("stall.fetch_pc", 64'(fetch_pc), 64'(m_pc));
      check("stall.commit_ready", 64'(commit_ready), 64'd0);
    end
    commit_valid = 1'b0;
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    check("fetch.commit_ready", 64'(commit_ready), 64'd1);
    check("fetch.fetch_valid", 64'(fetch_valid), 64'd0);
  endtask

  task automatic do_commit(input logic [1:0] src, input logic [31:0] im,
                           input logic [31:0] alu, input int delay);
    logic [31:0] t;
    for (int i = 0; i < delay; i++) begin
      tick();
      check("exec.commit_ready", 64'(commit_ready), 64'd1);
    end
    pc_src = src; imm = im; alu_result = alu; commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    case (src)
      2'd0:    t = m_pc + 32'd4;
      2'd1:    t = m_pc + im;
      2'd2:    t = alu - (alu % 2);
      default: t = alu;
    endcase
    if (src != 2'd3 && (t % 4) == 0) begin
      m_pc = t;
      m_instret = m_instret + 1;
    end else begin
      m_halted = 1'b1;
      m_bad = t;
    end
    check_arch("commit");
    check("commit.commit_ready", 64'(commit_ready), 64'd0);
    check("commit.fetch_valid", 64'(fetch_valid), 64'(!m_halted));
  endtask

  // Halt must be sticky and ignore commit attempts.
  task automatic check_halt_sticky(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      commit_valid = 1'b1;
      fetch_ready = 1'b1;
      pc_src = 2'd0;
      tick();
      check("halt.fetch_valid", 64'(fetch_valid), 64'd0);
      check("halt.commit_ready", 64'(commit_ready), 64'd0);
      check_arch("halt");
    end
    commit_valid = 1'b0;
    fetch_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc_src = '0; imm = '0; alu_result = '0;
    commit_valid = 1'b0; fetch_ready = 1'b0;
    tick();
    do_reset();

    // Boot: one idle cycle, then fetch from the reset vector.
    fetch_ready = 1'b1;
    tick();
    check("boot.fetch_valid", 64'(fetch_valid), 64'd1);
    check("boot.fetch_pc", 64'(fetch_pc), 64'(c_reset_vec));
    tick();
    fetch_ready = 1'b0;
    check("boot.commit_ready", 64'(commit_ready), 64'd1);

    // Sequential commits and branch/jalr
    do_commit(2'd0, 32'h0, 32'h0, 0);
    do_fetch(0); do_commit(2'd0, 32'h0, 32'h0, 1);
    do_fetch(1); do_commit(2'd0, 32'h0, 32'h0, 0);
    check("seq.pc", 64'(pc), 64'h8000_000C);
    check("seq.instret", instret, 64'd3);
    do_fetch(0); do_commit(2'd0, 32'h0, 32'h0, 0);
    do_fetch(0); do_commit(2'd1, 32'hFFFF_FFF8, 32'h0, 0);
    check("branch.pc", 64'(pc), 64'h8000_0008);
    do_fetch(0); do_commit(2'd2, 32'h0, 32'h8000_1001, 0);
    check("jalr.pc", 64'(pc), 64'h8000_1000);

    // Wrap-around of the PC
    do_fetch(0); do_commit(2'd2, 32'h0, 32'hFFFF_FFFC, 0);
    do_fetch(0); do_commit(2'd0, 32'h0, 32'h0, 0);
    check("wrap.pc", 64'(pc), 64'h0);

    // Misaligned branch target
    do_reset();
    do_fetch(0); do_commit(2'd1, 32'h0000_0002, 32'h0, 0);
    check("misalign.bad", 64'(bad_target), 64'h8000_0002);
    check_halt_sticky(3);

    // Illegal select
    do_reset();
    do_fetch(0); do_commit(2'd3, 32'h0, 32'h1234_5678, 0);
    check("illegal.bad", 64'(bad_target), 64'h1234_5678);
    check_halt_sticky(2);

    // Backpressure then reset mid-wait
    do_reset();
    do_fetch(0); do_commit(2'd0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.fetch_valid", 64'(fetch_valid), 64'd1);
      check("bp.fetch_pc", 64'(fetch_pc), 64'h8000_0004);
    end
    do_reset();

    // Randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      logic [1:0]  src;
      logic [31:0] im, alu;
      src = (($urandom % 16) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      im  = $urandom;
      alu = $urandom;
      if (($urandom % 8) != 0) begin
        im  = im & 32'hFFFF_FFFC;
        alu = alu & 32'hFFFF_FFFD;
      end
      do_fetch($urandom_range(0, 2));
      do_commit(src, im, alu, $urandom_range(0, 2));
      if (m_halted) begin
        check_halt_sticky(2);
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
